// File: rtl/prim_clock_div_stepdown.sv
// Even-ratio clock divider built on a registered toggle, with an optional step-down
// to twice the ratio that only takes effect when the divided clock falls.
module prim_clock_div_stepdown #(
    parameter int unsigned Divisor    = 4,
    parameter logic        ResetValue = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic step_down_req_i,
    output logic step_down_ack_o,
    input  logic scanmode_i,
    output logic clk_o
);

    localparam int unsigned CntW = $clog2(Divisor) + 1;
    localparam logic [CntW-1:0] HalfM1Base = CntW'(Divisor / 2 - 1);
    localparam logic [CntW-1:0] HalfM1Step = CntW'(Divisor - 1);

    if ((Divisor < 2) || ((Divisor % 2) != 0)) begin : gen_bad_divisor
        $error("prim_clock_div_stepdown: Divisor must be even and >= 2");
    end

    typedef enum logic {
        ModeBase     = 1'b0,
        ModeStepDown = 1'b1
    } mode_e;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            clk_int_q, clk_int_d;
    mode_e           mode_q, mode_d;
    logic [CntW-1:0] half_m1;
    logic            wrap;
    logic            boundary;

    // Mode only changes as clk_int falls, so both phases of a period use the same HALF.
    always_comb begin
        half_m1   = (mode_q == ModeStepDown) ? HalfM1Step : HalfM1Base;
        wrap      = (cnt_q == half_m1);
        boundary  = wrap && clk_int_q;
        cnt_d     = wrap ? '0 : cnt_q + CntW'(1);
        clk_int_d = clk_int_q ^ wrap;
        mode_d    = mode_q;
        if (boundary) begin
            mode_d = step_down_req_i ? ModeStepDown : ModeBase;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            clk_int_q <= ResetValue;
            mode_q    <= ModeBase;
        end else begin
            cnt_q     <= cnt_d;
            clk_int_q <= clk_int_d;
            mode_q    <= mode_d;
        end
    end

    assign step_down_ack_o = (mode_q == ModeStepDown);
    assign clk_o           = scanmode_i ? clk_i : clk_int_q;

endmodule

// File: tb/tb_prim_clock_div_stepdown.sv
// Scoreboard bench for prim_clock_div_stepdown: three instances (Divisor 2, 4, 8) driven by
// directed per-cycle vectors whose expected clk_o/ack levels are hand-computed.
module tb_prim_clock_div_stepdown;

    logic       clk_i    = 1'b0;
    logic       rst_i    = 1'b1;
    logic       scanmode = 1'b0;
    logic [2:0] req      = 3'b000;
    logic       clk_o_d2, clk_o_d4, clk_o_d8;
    logic       ack_d2, ack_d4, ack_d8;

    typedef struct {
        int   dut;
        int   test_id;
        int   idx;
        logic exp_clk;
        logic exp_ack;
    } exp_t;

    exp_t sb[$];
    int   n_vectors     = 0;
    int   n_miscompares = 0;
    event mon_tick;

    always #10 clk_i = ~clk_i;

    prim_clock_div_stepdown #(.Divisor(2), .ResetValue(1'b0)) u_div2 (
        .clk_i(clk_i), .rst_i(rst_i), .step_down_req_i(req[0]),
        .step_down_ack_o(ack_d2), .scanmode_i(scanmode), .clk_o(clk_o_d2)
    );
    prim_clock_div_stepdown #(.Divisor(4), .ResetValue(1'b0)) u_div4 (
        .clk_i(clk_i), .rst_i(rst_i), .step_down_req_i(req[1]),
        .step_down_ack_o(ack_d4), .scanmode_i(scanmode), .clk_o(clk_o_d4)
    );
    prim_clock_div_stepdown #(.Divisor(8), .ResetValue(1'b0)) u_div8 (
        .clk_i(clk_i), .rst_i(rst_i), .step_down_req_i(req[2]),
        .step_down_ack_o(ack_d8), .scanmode_i(scanmode), .clk_o(clk_o_d8)
    );

    function automatic string test_name(input int id);
        case (id)
            1:       return "d4_reset";
            2:       return "d4_div";
            3:       return "d4_step_up";
            4:       return "d4_step_drop";
            5:       return "d4_pulse";
            6:       return "d4_scan";
            7:       return "d4_prearm";
            8:       return "d4_async_rst";
            9:       return "d4_resume";
            10:      return "d2_reset";
            11:      return "d2_div";
            12:      return "d2_step_up";
            13:      return "d8_reset";
            14:      return "d8_div";
            15:      return "d8_step_up";
            default: return "drain";
        endcase
    endfunction

    function automatic logic char_bit(input byte c);
        return (c == 8'h31);
    endfunction

    task automatic checkOutput(input exp_t e);
        logic act_clk, act_ack;
        case (e.dut)
            0:       begin act_clk = clk_o_d2; act_ack = ack_d2; end
            1:       begin act_clk = clk_o_d4; act_ack = ack_d4; end
            default: begin act_clk = clk_o_d8; act_ack = ack_d8; end
        endcase
        n_vectors++;
        if ((act_clk !== e.exp_clk) || (act_ack !== e.exp_ack)) begin
            n_miscompares++;
            $display("[TB] FAIL %s[%0d] dut%0d: got clk_o=%b ack=%b, expected clk_o=%b ack=%b",
                     test_name(e.test_id), e.idx, e.dut, act_clk, act_ack, e.exp_clk, e.exp_ack);
        end
    endtask

    task automatic pushExp(input int dut, input int test_id, input int idx,
                           input logic c, input logic a);
        exp_t e;
        e.dut = dut; e.test_id = test_id; e.idx = idx; e.exp_clk = c; e.exp_ack = a;
        sb.push_back(e);
    endtask

    // One clk_i cycle: inputs change 1 unit after the rising edge; two samples follow
    // (high half and low half), so scan bypass must show clk_i's 1 then 0.
    task automatic applyStimulus(input int dut, input int test_id, input int idx,
                                 input logic req_b, input logic scan_b,
                                 input logic clk_b, input logic ack_b);
        @(posedge clk_i);
        #1;
        req[dut] = req_b;
        scanmode = scan_b;
        if (scan_b) begin
            pushExp(dut, test_id, idx, 1'b1, ack_b);
            pushExp(dut, test_id, idx, 1'b0, ack_b);
        end else begin
            pushExp(dut, test_id, idx, clk_b, ack_b);
            pushExp(dut, test_id, idx, clk_b, ack_b);
        end
    endtask

    task automatic runVectors(input int dut, input int test_id, input string req_s,
                              input string scan_s, input string clk_s, input string ack_s);
        for (int i = 0; i < clk_s.len(); i++) begin
            applyStimulus(dut, test_id, i, char_bit(req_s[i]), char_bit(scan_s[i]),
                          char_bit(clk_s[i]), char_bit(ack_s[i]));
        end
    endtask

    task automatic checkNow(input int dut, input int test_id, input logic c, input logic a);
        pushExp(dut, test_id, 0, c, a);
        ->mon_tick;
        #1;
    endtask

    // Reset is asserted between clock edges so the outputs must react asynchronously.
    task automatic doReset(input int test_id, input bit pre_check);
        req      = 3'b000;
        scanmode = 1'b0;
        @(negedge clk_i);
        #3;
        if (pre_check) checkNow(1, test_id, 1'b1, 1'b1);
        rst_i = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) checkNow(d, test_id, 1'b0, 1'b0);
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk_i);
            #2 ->mon_tick;
            @(negedge clk_i);
            #2 ->mon_tick;
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(mon_tick);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of stimulus, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        doReset(1, 1'b0);
        runVectors(1, 2, "000000000000", "000000000000", "011001100110", "000000000000");
        runVectors(1, 3, "011111111111111", "000000000000000",
                   "011000011110000", "000111111111111");
        runVectors(1, 4, "000000000000", "000000000000", "111100110011", "111100000000");
        runVectors(1, 5, "01000000", "00000000", "00110011", "00000000");
        runVectors(1, 6, "000000000", "111110000", "ccccc0110", "000000000");
        runVectors(1, 7, "111111111", "000000000", "011000011", "000111111");
        doReset(8, 1'b1);
        runVectors(1, 9, "000000000000", "000000000000", "011001100110", "000000000000");

        doReset(10, 1'b0);
        runVectors(0, 11, "00000000", "00000000", "10101010", "00000000");
        runVectors(0, 12, "1111111111", "0000000000", "1001100110", "0111111111");

        doReset(13, 1'b0);
        runVectors(2, 14, "0000000000000000", "0000000000000000",
                   "0001111000011110", "0000000000000000");
        runVectors(2, 15, "000011111111111111111111", "000000000000000000000000",
                   "000111100000000111111110", "000000011111111111111111");

        for (int k = 0; k < 8; k++) begin
            if (sb.size() == 0) break;
            @(negedge clk_i);
            #3;
        end
        n_vectors++;
        if (sb.size() != 0) begin
            n_miscompares++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
